// File: rtl/rs232_pkt_pkg.sv
// Shared types and default constants for the RS232 receive packet controller.
// Latency: n/a. Backpressure: n/a.
package rs232_pkt_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CSUM    = 3'd3,
    EMIT    = 3'd4
  } pkt_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         MAX_LEN   = 16;

endpackage

// File: rtl/rs232_pkt_buffer.sv
// Payload register file: one synchronous write port, one combinational read port.
// Latency: write visible the cycle after; read is same-cycle. Backpressure: none.
module rs232_pkt_buffer #(
  parameter int MAX_LEN = 16,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [7:0]    i_wr_dat,
  input  logic [AW-1:0] i_rd_addr,
  output logic [7:0]    o_rd_dat
);

  logic [7:0] r_mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/rs232_rx_packet_controller.sv
// Drains the deserializer FIFO, frames SYNC/LEN/payload/CSUM packets and streams good payloads out.
// Latency: CSUM pop to first out_valid is 1 cycle. Backpressure: out_ready stalls EMIT; no pops while emitting.
module rs232_rx_packet_controller #(
  parameter int          DATA_WIDTH     = 9,
  parameter int          MAX_LEN        = rs232_pkt_pkg::MAX_LEN,
  parameter logic [7:0]  SYNC_BYTE      = rs232_pkt_pkg::SYNC_BYTE,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd434000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            fifo_read_available,
  input  logic [DATA_WIDTH-1:0] received_data,
  output logic                  receive_data_en,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [7:0]            err_count,
  output logic                  busy
);
  import rs232_pkt_pkg::*;

  localparam int IW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  pkt_state_t    r_state;
  pkt_state_t    w_state_nxt;
  logic [1:0]    r_holdoff;
  logic [19:0]   r_gap;
  logic [7:0]    r_sum;
  logic [IW-1:0] r_len;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_ridx;
  logic          r_rden;
  logic [7:0]    r_out_data;
  logic          r_out_valid;
  logic          r_out_last;
  logic [7:0]    r_err;
  logic          r_busy;

  logic [7:0]    w_byte;
  logic          w_can_pop;
  logic          w_timeout;
  logic          w_pop;
  logic          w_err;
  logic          w_wr_en;
  logic          w_emit_start;
  logic          w_emit_adv;
  logic          w_emit_done;
  logic [IW-1:0] w_ridx_nxt;
  logic [7:0]    w_rd_data;
  logic          w_unused;

  assign w_byte    = received_data[7:0];
  assign w_unused  = &{1'b0, received_data[DATA_WIDTH-1:8]};
  assign w_can_pop = (fifo_read_available != 8'd0) && (r_holdoff == 2'd0);
  assign w_timeout = (r_gap >= TIMEOUT_CYCLES - 20'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pop        = 1'b0;
    w_err        = 1'b0;
    w_wr_en      = 1'b0;
    w_emit_start = 1'b0;
    w_emit_adv   = 1'b0;
    w_emit_done  = 1'b0;
    case (r_state)
      HUNT: begin
        if (w_can_pop) begin
          w_pop = 1'b1;
          if (w_byte == SYNC_BYTE) w_state_nxt = LEN;
        end
      end
      LEN: begin
        if (w_can_pop) begin
          w_pop = 1'b1;
          if (w_byte == 8'd0 || w_byte > 8'(MAX_LEN)) begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_state_nxt = PAYLOAD;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      PAYLOAD: begin
        if (w_can_pop) begin
          w_pop   = 1'b1;
          w_wr_en = 1'b1;
          if (r_idx == r_len - IW'(1)) w_state_nxt = CSUM;
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      CSUM: begin
        if (w_can_pop) begin
          w_pop = 1'b1;
          if (w_byte == r_sum) begin
            w_emit_start = 1'b1;
            w_state_nxt  = EMIT;
          end else begin
            w_err       = 1'b1;
            w_state_nxt = HUNT;
          end
        end else if (w_timeout) begin
          w_err       = 1'b1;
          w_state_nxt = HUNT;
        end
      end
      EMIT: begin
        if (r_out_valid && out_ready) begin
          if (r_out_last) begin
            w_emit_done = 1'b1;
            w_state_nxt = HUNT;
          end else begin
            w_emit_adv = 1'b1;
          end
        end
      end
      default: w_state_nxt = HUNT;
    endcase
  end

  // Read address runs one ahead of the presented byte so out_data is registered.
  assign w_ridx_nxt = w_emit_start ? '0 : r_ridx + IW'(1);

  rs232_pkt_buffer #(
    .MAX_LEN (MAX_LEN),
    .AW      (AW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_idx[AW-1:0]),
    .i_wr_dat  (w_byte),
    .i_rd_addr (w_ridx_nxt[AW-1:0]),
    .o_rd_dat  (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_holdoff   <= 2'd0;
      r_gap       <= 20'd0;
      r_sum       <= 8'd0;
      r_len       <= '0;
      r_idx       <= '0;
      r_ridx      <= '0;
      r_rden      <= 1'b0;
      r_out_data  <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_err       <= 8'd0;
      r_busy      <= 1'b0;
    end else begin
      r_rden <= w_pop;
      r_busy <= (w_state_nxt != HUNT);
      // Status input trails a pop by two cycles, so hold off re-reading it.
      if (w_pop) begin
        r_holdoff <= 2'd2;
      end else if (r_holdoff != 2'd0) begin
        r_holdoff <= r_holdoff - 2'd1;
      end
      if (w_pop || r_state == HUNT || r_state == EMIT || w_state_nxt == HUNT) begin
        r_gap <= 20'd0;
      end else begin
        r_gap <= r_gap + 20'd1;
      end
      if (w_pop && r_state == LEN) begin
        r_len <= w_byte[IW-1:0];
        r_sum <= w_byte;
        r_idx <= '0;
      end else if (w_wr_en) begin
        r_sum <= r_sum + w_byte;
        r_idx <= r_idx + IW'(1);
      end
      if (w_err && r_err != 8'hFF) begin
        r_err <= r_err + 8'd1;
      end
      if (w_emit_start) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_rd_data;
        r_out_last  <= (r_len == IW'(1));
        r_ridx      <= '0;
      end else if (w_emit_adv) begin
        r_out_data  <= w_rd_data;
        r_out_last  <= (w_ridx_nxt == r_len - IW'(1));
        r_ridx      <= w_ridx_nxt;
      end else if (w_emit_done) begin
        r_out_valid <= 1'b0;
        r_out_last  <= 1'b0;
      end
    end
  end

  assign receive_data_en = r_rden;
  assign out_data        = r_out_data;
  assign out_valid       = r_out_valid;
  assign out_last        = r_out_last;
  assign err_count       = r_err;
  assign busy            = r_busy;

endmodule

// File: doc/rs232_rx_packet_controller.md
# rs232_rx_packet_controller

Sequencer that drains the RS232 receive FIFO of the serial-in deserializer and frames the byte stream into validated packets. It owns the FIFO read strobe, hunts for a sync byte, collects length and payload into a local buffer, checks an 8-bit sum, and releases only good packets to the downstream consumer over a valid/ready stream. Malformed or stalled packets are dropped and counted.

## Interface
- DATA_WIDTH, 9: width of the deserializer FIFO word; only bits [7:0] are used, the upper bits are ignored.
- MAX_LEN, 16: maximum payload bytes per packet; buffer depth.
- SYNC_BYTE, 8'hA5: start-of-packet marker.
- TIMEOUT_CYCLES, 20'd434000: maximum clk cycles between bytes inside a packet.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- fifo_read_available  in  8  registered FIFO status: {full, words_used[6:0]}.
- received_data  in  DATA_WIDTH  FIFO head word (show-ahead; valid whenever FIFO non-empty).
- receive_data_en  out  1  one-cycle pop strobe to the FIFO.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data valid.
- out_last  out  1  final payload byte of the packet.
- out_ready  in  1  consumer accepts the byte when out_valid & out_ready.
- err_count  out  8  saturating count of dropped packets.
- busy  out  1  high in any state except HUNT.

## Operation
- Frame: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, CSUM. CSUM is the 8-bit sum mod 256 of LEN and all payload bytes.
- FIFO non-empty means fifo_read_available != 0. Pops happen only in HUNT, LEN, PAYLOAD and CSUM, when the FIFO is non-empty and holdoff == 0.
- A pop asserts receive_data_en for 1 cycle and captures received_data[7:0] in that same cycle. It then loads holdoff = 2, because the status input lags the pop by 2 cycles.
- States and transitions:
  - HUNT: pop; byte == SYNC_BYTE -> LEN; any other byte is discarded silently.
  - LEN: pop; LEN == 0 or LEN > MAX_LEN -> error, go to HUNT. Otherwise store len, set sum = LEN, go to PAYLOAD.
  - PAYLOAD: pop; write the byte to buf[idx] and add it to sum; after idx == len-1 -> CSUM.
  - CSUM: pop; byte == sum -> EMIT, else error -> HUNT.
  - EMIT: no pops. Present buf[0..len-1] in order; out_last is high on the byte with index len-1. After the last byte is accepted -> HUNT.
- Error: err_count increments, saturating at 8'hFF; the partial packet is discarded.
- Timeout: in LEN, PAYLOAD and CSUM, a gap counter counts cycles since the last pop. Reaching TIMEOUT_CYCLES is an error -> HUNT. The counter clears on every pop and in HUNT/EMIT.
- Arithmetic: sum is 8-bit wrap-around; idx and len are clog2(MAX_LEN+1) bits wide.
- A full FIFO (bit 7 set) needs no special action; pops continue as normal.

## Timing
- Reset values: receive_data_en=0, out_valid=0, out_last=0, out_data=0, err_count=0, busy=0, state=HUNT, holdoff=0.
- All outputs are registered.
- Maximum pop rate is 1 per 3 cycles.
- CSUM pop to first out_valid: 1 cycle.
- EMIT: out_valid stays high, and out_data/out_last are held stable, until the handshake completes. With out_ready held high, one byte is transferred per cycle.
- Reset asserted mid-packet returns the block to HUNT immediately. Packet contents are lost and err_count clears; FIFO words are not touched.
- When an error and the err_count saturation limit coincide, err_count stays at 8'hFF.

## Structure
- Shared package rs232_pkt_pkg holds:
  - the state enum (HUNT, LEN, PAYLOAD, CSUM, EMIT);
  - default constants SYNC_BYTE and MAX_LEN.
- One sub-module, rs232_pkt_buffer: MAX_LEN x 8 register file with one synchronous write port and one combinational read port.
- The FSM, holdoff counter, gap counter and checksum stay in the top level.

## Test plan
- Good frame: FIFO holds A5 03 11 22 33 69 -> out bytes 11, 22, 33 with out_last on 33; err_count stays 0; pops are spaced at least 3 cycles apart.
- Bad checksum: A5 02 01 02 00 -> no out_valid; err_count=1; then A5 01 7F 80 yields byte 7F with out_last.
- Bad length: A5 00 and A5 11 (MAX_LEN=16) -> err_count=2, no output; garbage bytes 00 FF before a good frame are dropped silently.
- Back-pressure: good 4-byte frame with out_ready toggling 1,0,0,1 -> each byte is held stable until accepted; no FIFO pops during EMIT.
- Timeout: A5 02 01, then no bytes for TIMEOUT_CYCLES -> err_count=1, busy drops. A late 02 04 is discarded in HUNT.
- Reset: assert reset_n=0 during PAYLOAD -> all outputs at reset values within the same cycle; after release, the next good frame is delivered intact.
